hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS pipeline; it sits beside the forwarding unit.
- Detects hazards that forwarding cannot cover:
  - load-use in EX;
  - branch operands resolved in ID that are not yet available;
  - HI/LO accesses while the multi-cycle multiply/divide unit is busy.
- Drives PC/IF-ID write enables, ID/EX bubble insertion and IF/ID flush on taken control transfers.
- Owns the mul/div busy counter.

Parameters:
MUL_CYCLES, 4, total EX occupancy of mult/multu in cycles (1..63)
DIV_CYCLES, 32, total EX occupancy of div/divu in cycles (1..63)
CNT_W, 6, width of busy counter; must hold max(MUL_CYCLES,DIV_CYCLES)-1

Ports:
clk  input  1  pipeline clock
rst  input  1  asynchronous active-high reset
reg_rs_ID  input  5  rs of instruction in ID
reg_rt_ID  input  5  rt of instruction in ID
use_rs_ID  input  1  ID instruction reads rs
use_rt_ID  input  1  ID instruction reads rt
branch_ID  input  1  ID instruction is a branch/jr comparing registers in ID
taken_ID  input  1  branch/jump in ID resolved taken (valid only when not stalled)
hilo_read_ID  input  1  ID instruction is mfhi/mflo
muldiv_ID  input  1  ID instruction is mult/div family
reg_rd_EX  input  5  destination of EX instruction
regwrite_EX  input  1  EX instruction writes a register
memread_EX  input  1  EX instruction is a load
muldiv_start_EX  input  1  mul/div op in its first EX cycle
div_EX  input  1  1 = divide, 0 = multiply (qualifies muldiv_start_EX)
reg_rd_MEM  input  5  destination of MEM instruction
memread_MEM  input  1  MEM instruction is a load
pc_write  output  1  PC update enable
ifid_write  output  1  IF/ID register write enable
idex_flush  output  1  insert bubble into ID/EX
ifid_flush  output  1  squash instruction in IF/ID
muldiv_busy  output  1  mul/div unit occupied; HI/LO not valid
stall_cycles  output  32  perf counter (see Optional Feature)
flush_count  output  32  perf counter (see Optional Feature)

Behaviour:
- Reset: asynchronous on rst=1, so outputs are forced while rst is held and take effect without waiting for clk.
  - Counters clear to 0.
  - pc_write=1, ifid_write=1, idex_flush=0, ifid_flush=0, muldiv_busy=0.
- Match(r,en): en && r!=0 && r==src, evaluated against reg_rs_ID/use_rs_ID and reg_rt_ID/use_rt_ID.
- load_use = memread_EX && Match(reg_rd_EX).
- br_haz = branch_ID && ((regwrite_EX && Match(reg_rd_EX)) || (memread_MEM && Match(reg_rd_MEM))).
  - ALU results in MEM are covered by forwarding and do not stall.
- busy counter cnt (CNT_W bits), registered:
  - On muldiv_start_EX, load (div_EX ? DIV_CYCLES : MUL_CYCLES)-1.
  - Otherwise, if cnt!=0, decrement.
  - Start while cnt!=0 reloads (restart); this is prevented by the stall logic in normal flow.
  - Start with cycles=1 loads 0, i.e. no busy window.
- muldiv_busy = (cnt!=0) || muldiv_start_EX with loaded value >0. Combinational from cnt and start.
- hilo_haz = (hilo_read_ID || muldiv_ID) && muldiv_busy.
- stall = load_use || br_haz || hilo_haz.
  - While stall=1: pc_write=0, ifid_write=0, idex_flush=1.
- ifid_flush = taken_ID && !stall. A taken indication during a stall is ignored until operands are ready.
- All stall/flush outputs are combinational, same-cycle. Latency from hazard to bubble is 0 cycles.
- Stall persistence:
  - load_use lasts exactly 1 cycle.
  - br_haz on an EX ALU producer lasts 1 cycle.
  - br_haz on an EX load producer lasts 2 cycles (EX, then MEM load).
  - hilo_haz lasts until cnt returns to 0.
- A hazard on register 0 never stalls.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined:
  - stall_cycles increments every clk with stall=1.
  - flush_count increments every clk with ifid_flush=1.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and clear on rst.
- Undefined: both ports are tied to 0 and no counter registers are synthesised.

Test Plan:
- Load-use: lw $8 in EX (memread_EX=1, reg_rd_EX=8), ID add uses rs=8 → exactly 1 cycle pc_write=0, ifid_write=0, idex_flush=1, then all released.
- Branch on EX load: lw $9 in EX, beq $9 in ID (branch_ID=1) → stall 2 cycles (EX, then memread_MEM, reg_rd_MEM=9); taken_ID=1 during the stall gives ifid_flush=0; first cycle after the stall gives ifid_flush=1.
- $0 immunity: memread_EX=1, reg_rd_EX=0, use_rs_ID=1 with rs=0 → no stall.
- Divide busy: muldiv_start_EX=1, div_EX=1, then mflo in ID → muldiv_busy and stall held for 31 cycles after the start cycle, released when cnt=0; with MUL (div_EX=0) → 3 cycles.
- Async reset mid-divide: rst pulsed at cnt=17 without a clk edge → muldiv_busy=0 and pc_write=1 immediately; cnt=0 after release.
- With HAZARD_PERF_CNT_EN: run the load-use and divide scenarios → stall_cycles=1+31=32; three taken branches → flush_count=3; without the macro both read 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use, ID-branch operand and HI/LO-busy interlocks, plus mul/div busy counter.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  reg_rs_ID,
    input  logic [4:0]  reg_rt_ID,
    input  logic        use_rs_ID,
    input  logic        use_rt_ID,
    input  logic        branch_ID,
    input  logic        taken_ID,
    input  logic        hilo_read_ID,
    input  logic        muldiv_ID,
    input  logic [4:0]  reg_rd_EX,
    input  logic        regwrite_EX,
    input  logic        memread_EX,
    input  logic        muldiv_start_EX,
    input  logic        div_EX,
    input  logic [4:0]  reg_rd_MEM,
    input  logic        memread_MEM,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_flush,
    output logic        ifid_flush,
    output logic        muldiv_busy,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    localparam int unsigned      REG_W       = 5;
    localparam logic [CNT_W-1:0] MUL_LOAD    = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD    = CNT_W'(DIV_CYCLES - 1);
    localparam logic [31:0]      PERF_MAX    = 32'hFFFF_FFFF;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_load;
    logic             w_match_ex;
    logic             w_match_mem;
    logic             w_load_use;
    logic             w_br_haz;
    logic             w_busy;
    logic             w_hilo_haz;
    logic             w_stall;
    logic             w_flush;

    // A source match ignores $0, which is hard-wired and never a real dependency.
    assign w_match_ex  = (reg_rd_EX != REG_W'(0)) &&
                         ((use_rs_ID && (reg_rd_EX == reg_rs_ID)) ||
                          (use_rt_ID && (reg_rd_EX == reg_rt_ID)));
    assign w_match_mem = (reg_rd_MEM != REG_W'(0)) &&
                         ((use_rs_ID && (reg_rd_MEM == reg_rs_ID)) ||
                          (use_rt_ID && (reg_rd_MEM == reg_rt_ID)));

    assign w_load_use  = memread_EX && w_match_ex;
    assign w_br_haz    = branch_ID &&
                         ((regwrite_EX && w_match_ex) || (memread_MEM && w_match_mem));

    assign w_load      = div_EX ? DIV_LOAD : MUL_LOAD;
    // Busy covers the start cycle itself unless the op is single-cycle.
    assign w_busy      = !rst && ((r_cnt != '0) || (muldiv_start_EX && (w_load != '0)));
    assign w_hilo_haz  = (hilo_read_ID || muldiv_ID) && w_busy;

    // Reset forces the free-running (non-stalling) output state without a clock.
    assign w_stall     = !rst && (w_load_use || w_br_haz || w_hilo_haz);
    assign w_flush     = !rst && taken_ID && !w_stall;

    assign pc_write    = !w_stall;
    assign ifid_write  = !w_stall;
    assign idex_flush  = w_stall;
    assign ifid_flush  = w_flush;
    assign muldiv_busy = w_busy;

    // Remaining busy cycles after the current one; a new start always reloads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (muldiv_start_EX) begin
            r_cnt <= w_load;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall && (r_stall_cycles != PERF_MAX)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_flush && (r_flush_count != PERF_MAX)) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a timestamp-based model.
module tb_hazard_ctrl;

    localparam int MUL_N = 4;
    localparam int DIV_N = 32;

    logic        clk;
    logic        rst;
    logic [4:0]  reg_rs_ID, reg_rt_ID, reg_rd_EX, reg_rd_MEM;
    logic        use_rs_ID, use_rt_ID, branch_ID, taken_ID, hilo_read_ID, muldiv_ID;
    logic        regwrite_EX, memread_EX, muldiv_start_EX, div_EX, memread_MEM;
    logic        pc_write, ifid_write, idex_flush, ifid_flush, muldiv_busy;
    logic [31:0] stall_cycles, flush_count;
    logic [4:0]  obs;

    int errors = 0;
    int checks = 0;

    // Model state: cycle index, last cycle the mul/div unit is busy, event counts.
    int m_cycle    = 0;
    int m_busy_end = -1;
    int m_stalls   = 0;
    int m_flushes  = 0;

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .reg_rs_ID(reg_rs_ID), .reg_rt_ID(reg_rt_ID),
        .use_rs_ID(use_rs_ID), .use_rt_ID(use_rt_ID),
        .branch_ID(branch_ID), .taken_ID(taken_ID),
        .hilo_read_ID(hilo_read_ID), .muldiv_ID(muldiv_ID),
        .reg_rd_EX(reg_rd_EX), .regwrite_EX(regwrite_EX), .memread_EX(memread_EX),
        .muldiv_start_EX(muldiv_start_EX), .div_EX(div_EX),
        .reg_rd_MEM(reg_rd_MEM), .memread_MEM(memread_MEM),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_flush(idex_flush),
        .ifid_flush(ifid_flush), .muldiv_busy(muldiv_busy),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    assign obs = {pc_write, ifid_write, idex_flush, ifid_flush, muldiv_busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    function automatic bit hits(input logic [4:0] r);
        return (r != 5'd0) && ((use_rs_ID && r == reg_rs_ID) || (use_rt_ID && r == reg_rt_ID));
    endfunction

    // Expected {pc_write, ifid_write, idex_flush, ifid_flush, muldiv_busy} for the current cycle.
    function automatic logic [4:0] exp_outs();
        bit lu, br, busy, stall, fl;
        int n;
        n     = div_EX ? DIV_N : MUL_N;
        lu    = memread_EX && hits(reg_rd_EX);
        br    = branch_ID && ((regwrite_EX && hits(reg_rd_EX)) || (memread_MEM && hits(reg_rd_MEM)));
        busy  = muldiv_start_EX ? (n > 1) : (m_cycle <= m_busy_end);
        stall = lu || br || ((hilo_read_ID || muldiv_ID) && busy);
        fl    = taken_ID && !stall;
        return {!stall, !stall, stall, fl, busy};
    endfunction

    task automatic set_idle();
        reg_rs_ID = 0; reg_rt_ID = 0; reg_rd_EX = 0; reg_rd_MEM = 0;
        use_rs_ID = 0; use_rt_ID = 0; branch_ID = 0; taken_ID = 0;
        hilo_read_ID = 0; muldiv_ID = 0; regwrite_EX = 0; memread_EX = 0;
        muldiv_start_EX = 0; div_EX = 0; memread_MEM = 0;
    endtask

    // Advance the model by one clock with the current inputs, then the real clock.
    task automatic tick();
        logic [4:0] e;
        int n;
        e = exp_outs();
        if (e[2]) m_stalls++;
        if (e[1]) m_flushes++;
        if (muldiv_start_EX) begin
            n = div_EX ? DIV_N : MUL_N;
            m_busy_end = (n > 1) ? m_cycle + n - 1 : m_cycle;
        end
        @(posedge clk);
        #1;
        m_cycle++;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_busy_end = -1;
        m_stalls   = 0;
        m_flushes  = 0;
        m_cycle++;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        memread_EX = 1; regwrite_EX = 1; reg_rd_EX = 5'd8; use_rs_ID = 1; reg_rs_ID = 5'd8;
        muldiv_start_EX = 1; div_EX = 1; hilo_read_ID = 1; taken_ID = 1;
        #1;
        checks++;
        if (obs !== 5'b11000) begin
            errors++; $display("FAIL reset_outputs: got %b want %b", obs, 5'b11000);
        end
        @(posedge clk); #1; @(posedge clk); #1;
        checks++;
        if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cycles, flush_count);
        end
        checks++;
        if (obs !== 5'b11000) begin
            errors++; $display("FAIL reset_held: got %b want %b", obs, 5'b11000);
        end
        set_idle();
        rst = 1'b0;
        m_busy_end = -1; m_stalls = 0; m_flushes = 0;
        @(negedge clk);
        checks++;
        if (muldiv_busy !== 1'b0) begin
            errors++; $display("FAIL reset_cnt_clear: got busy=%b want 0", muldiv_busy);
        end
        tick();
    endtask

    task automatic test_load_use();
        set_idle();
        memread_EX = 1; regwrite_EX = 1; reg_rd_EX = 5'd8; use_rs_ID = 1; reg_rs_ID = 5'd8;
        @(negedge clk);
        checks++;
        if (obs !== 5'b00100) begin
            errors++; $display("FAIL load_use_stall: got %b want %b", obs, 5'b00100);
        end
        tick();
        memread_EX = 0; regwrite_EX = 0; reg_rd_EX = 0; memread_MEM = 1; reg_rd_MEM = 5'd8;
        @(negedge clk);
        checks++;
        if (obs !== 5'b11000) begin
            errors++; $display("FAIL load_use_release: got %b want %b", obs, 5'b11000);
        end
        tick();
        set_idle();
    endtask

    task automatic test_branch_load();
        set_idle();
        branch_ID = 1; taken_ID = 1; use_rs_ID = 1; reg_rs_ID = 5'd9;
        memread_EX = 1; regwrite_EX = 1; reg_rd_EX = 5'd9;
        @(negedge clk);
        checks++;
        if (obs !== 5'b00100) begin
            errors++; $display("FAIL br_load_ex: got %b want %b", obs, 5'b00100);
        end
        tick();
        memread_EX = 0; regwrite_EX = 0; reg_rd_EX = 0; memread_MEM = 1; reg_rd_MEM = 5'd9;
        @(negedge clk);
        checks++;
        if (obs !== 5'b00100) begin
            errors++; $display("FAIL br_load_mem: got %b want %b", obs, 5'b00100);
        end
        tick();
        memread_MEM = 0; reg_rd_MEM = 0;
        @(negedge clk);
        checks++;
        if (obs !== 5'b11010) begin
            errors++; $display("FAIL br_load_flush: got %b want %b", obs, 5'b11010);
        end
        tick();
        // ALU producer in EX: one stall, then forwarded from MEM.
        regwrite_EX = 1; reg_rd_EX = 5'd9;
        @(negedge clk);
        checks++;
        if (obs !== 5'b00100) begin
            errors++; $display("FAIL br_alu_ex: got %b want %b", obs, 5'b00100);
        end
        tick();
        regwrite_EX = 0; reg_rd_EX = 0; reg_rd_MEM = 5'd9;
        @(negedge clk);
        checks++;
        if (obs !== 5'b11010) begin
            errors++; $display("FAIL br_alu_mem: got %b want %b", obs, 5'b11010);
        end
        tick();
        set_idle();
    endtask

    task automatic test_zero_reg();
        set_idle();
        memread_EX = 1; regwrite_EX = 1; reg_rd_EX = 5'd0; use_rs_ID = 1; reg_rs_ID = 5'd0;
        @(negedge clk);
        checks++;
        if (obs !== 5'b11000) begin
            errors++; $display("FAIL zero_load_use: got %b want %b", obs, 5'b11000);
        end
        tick();
        memread_EX = 0; branch_ID = 1; use_rt_ID = 1; reg_rt_ID = 5'd0;
        memread_MEM = 1; reg_rd_MEM = 5'd0;
        @(negedge clk);
        checks++;
        if (obs !== 5'b11000) begin
            errors++; $display("FAIL zero_branch: got %b want %b", obs, 5'b11000);
        end
        tick();
        set_idle();
    endtask

    task automatic test_muldiv(input bit is_div, input int exp_n);
        int n_stall;
        set_idle();
        muldiv_start_EX = 1; div_EX = is_div;
        @(negedge clk);
        checks++;
        if (obs !== 5'b11001) begin
            errors++; $display("FAIL muldiv_start_%0d: got %b want %b", is_div, obs, 5'b11001);
        end
        tick();
        muldiv_start_EX = 0; hilo_read_ID = 1;
        n_stall = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (idex_flush !== 1'b1) break;
            if (muldiv_busy !== 1'b1 || pc_write !== 1'b0) begin
                errors++; $display("FAIL muldiv_hold_%0d: got %b want %b at %0d", is_div, obs, 5'b00101, i);
            end
            n_stall++;
            tick();
        end
        checks++;
        if (n_stall !== exp_n) begin
            errors++; $display("FAIL muldiv_len_%0d: got %0d want %0d", is_div, n_stall, exp_n);
        end
        checks++;
        if (obs !== 5'b11000) begin
            errors++; $display("FAIL muldiv_release_%0d: got %b want %b", is_div, obs, 5'b11000);
        end
        tick();
        set_idle();
    endtask

    task automatic test_divide();
        test_muldiv(1'b1, DIV_N - 1);
        test_muldiv(1'b0, MUL_N - 1);
    endtask

    task automatic test_async_reset();
        set_idle();
        muldiv_start_EX = 1; div_EX = 1;
        tick();
        muldiv_start_EX = 0; hilo_read_ID = 1;
        for (int i = 0; i < 64 && (m_busy_end - m_cycle) != 17; i++) tick();
        @(negedge clk);
        checks++;
        if (obs !== 5'b00101) begin
            errors++; $display("FAIL arst_pre: got %b want %b", obs, 5'b00101);
        end
        tick();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (muldiv_busy !== 1'b0 || pc_write !== 1'b1) begin
            errors++; $display("FAIL arst_immediate: got busy=%b pc_write=%b want 0/1", muldiv_busy, pc_write);
        end
        rst = 1'b0;
        m_busy_end = -1; m_stalls = 0; m_flushes = 0;
        @(negedge clk);
        checks++;
        if (obs !== 5'b11000) begin
            errors++; $display("FAIL arst_after: got %b want %b", obs, 5'b11000);
        end
        tick();
        set_idle();
    endtask

    task automatic test_random();
        logic [4:0] e;
        logic [31:0] exp_sc, exp_fc;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reg_rs_ID       = 5'($urandom_range(0, 3));
            reg_rt_ID       = 5'($urandom_range(0, 3));
            reg_rd_EX       = 5'($urandom_range(0, 3));
            reg_rd_MEM      = 5'($urandom_range(0, 3));
            use_rs_ID       = 1'($urandom_range(0, 1));
            use_rt_ID       = 1'($urandom_range(0, 1));
            branch_ID       = ($urandom_range(0, 3) == 0);
            taken_ID        = 1'($urandom_range(0, 1));
            hilo_read_ID    = ($urandom_range(0, 3) == 0);
            muldiv_ID       = ($urandom_range(0, 7) == 0);
            memread_EX      = ($urandom_range(0, 3) == 0);
            regwrite_EX     = memread_EX || 1'($urandom_range(0, 1));
            muldiv_start_EX = ($urandom_range(0, 11) == 0);
            div_EX          = 1'($urandom_range(0, 1));
            memread_MEM     = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            e = exp_outs();
            checks++;
            if (obs !== e) begin
                errors++; $display("FAIL random_%0d: got %b want %b", i, obs, e);
            end
            tick();
        end
        set_idle();
        @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
        exp_sc = 32'(m_stalls);
        exp_fc = 32'(m_flushes);
`else
        exp_sc = 32'd0;
        exp_fc = 32'd0;
`endif
        checks++;
        if (stall_cycles !== exp_sc || flush_count !== exp_fc) begin
            errors++; $display("FAIL random_perf: got %0d/%0d want %0d/%0d", stall_cycles, flush_count, exp_sc, exp_fc);
        end
        tick();
    endtask

    task automatic test_perf();
        logic [31:0] exp_sc, exp_fc;
        do_reset();
        test_load_use();
        test_muldiv(1'b1, DIV_N - 1);
        for (int i = 0; i < 3; i++) begin
            branch_ID = 1; taken_ID = 1;
            tick();
            set_idle();
            tick();
        end
        @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
        exp_sc = 32'd32;
        exp_fc = 32'd3;
`else
        exp_sc = 32'd0;
        exp_fc = 32'd0;
`endif
        checks++;
        if (stall_cycles !== exp_sc) begin
            errors++; $display("FAIL perf_stalls: got %0d want %0d", stall_cycles, exp_sc);
        end
        checks++;
        if (flush_count !== exp_fc) begin
            errors++; $display("FAIL perf_flushes: got %0d want %0d", flush_count, exp_fc);
        end
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        test_reset();
        test_load_use();
        test_branch_load();
        test_zero_reg();
        test_divide();
        test_async_reset();
        test_random();
        test_perf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
